sdrd_serial_reader: RTL and testbench

Bus-side initiator that reads the serial data line (SDRD) from the 0x1xxx serial-select window. On a start request it issues a fixed unlock sequence of read cycles, each at a specific BA7..BA4 pattern, then issues one read per data bit. On each bit read it samples SDRD on the acknowledge cycle and assembles the bits into a parallel word for the host. It sits between the host control logic and the board bus, on the opposite end of the SDRD responder.

---
 rtl/sdrd_pkg.sv | 23 ++
 rtl/sdrd_serial_reader_if.sv | 21 ++
 rtl/sdrd_ack_timer.sv | 34 +++
 rtl/sdrd_serial_reader.sv | 150 +++++++++++++++
 tb/tb_sdrd_serial_reader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdrd_pkg.sv
// Shared types and constants for the SDRD serial reader: FSM states, the
// serial-select window base, and the default unlock nibble sequence.
package sdrd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNLOCK = 3'd1,
    ST_UGAP   = 3'd2,
    ST_READ   = 3'd3,
    ST_RGAP   = 3'd4,
    ST_FIN    = 3'd5
  } sdrd_state_e;

  localparam logic [13:0] SDRD_WINDOW     = 14'h1000;
  localparam int          SDRD_NIB_LSB    = 4;
  localparam logic [31:0] SDRD_UNLOCK_SEQ = 32'h0000_98A2;

  // Places a BA7..BA4 nibble into the serial-select window address.
  function automatic logic [13:0] unlock_addr(input logic [3:0] nib);
    return SDRD_WINDOW | (14'(nib) << SDRD_NIB_LSB);
  endfunction

endpackage

// File: rtl/sdrd_serial_reader_if.sv
// Board-bus side of the SDRD reader: request/address out, ack/serial data in.
// Handshake: bus_req and bus_addr stay constant from the first request cycle
// until the cycle in which bus_ack is sampled high; ack with bus_req low means nothing.
interface sdrd_serial_reader_if;
  logic        bus_req;
  logic        sser_n;
  logic        br_w;
  logic [13:0] bus_addr;
  logic        bus_ack;
  logic        sdrd_in;

  modport master (
    output bus_req, sser_n, br_w, bus_addr,
    input  bus_ack, sdrd_in
  );

  modport slave (
    input  bus_req, sser_n, br_w, bus_addr,
    output bus_ack, sdrd_in
  );
endinterface

// File: rtl/sdrd_ack_timer.sv
// Acknowledge wait counter: held at zero by clr, counts while en, and
// saturates at TIMEOUT, where expired is raised.
module sdrd_ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  assign expired = (cnt_q == 8'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdrd_serial_reader.sv
// SDRD serial reader: issues the unlock read sequence, then one read per data
// bit, shifting SDRD (sampled on ack) into a parallel word, MSB first.
module sdrd_serial_reader
  import sdrd_pkg::*;
#(
  parameter int          NBITS      = 16,
  parameter int          UNLOCK_LEN = 4,
  parameter logic [31:0] UNLOCK_SEQ = SDRD_UNLOCK_SEQ,
  parameter int          TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NBITS-1:0]     data,
  output sdrd_state_e          state_dbg,
  sdrd_serial_reader_if.master bus
);

  localparam int CW = $clog2(NBITS + 1);

  sdrd_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bus_req_q, bus_req_d;
  logic             sser_n_q, sser_n_d;
  logic [13:0]      bus_addr_q, bus_addr_d;
  logic             req_active;
  logic             timer_expired;

  assign req_active = (state_q == ST_UNLOCK) || (state_q == ST_READ);

  sdrd_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!req_active),
    .en      (req_active && !bus.bus_ack),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_UNLOCK;
          idx_d     = '0;
          bit_cnt_d = '0;
          data_d    = '0;
          err_d     = 1'b0;
        end
      end
      // An ack in the cycle the timer expires still wins over the timeout.
      ST_UNLOCK: begin
        if (bus.bus_ack) begin
          state_d = ST_UGAP;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_UGAP: begin
        if (idx_q == 3'(UNLOCK_LEN - 1)) begin
          state_d = ST_READ;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_UNLOCK;
        end
      end
      ST_READ: begin
        if (bus.bus_ack) begin
          data_d    = NBITS'({data_q, bus.sdrd_in});
          bit_cnt_d = bit_cnt_q + CW'(1);
          state_d   = ST_RGAP;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_RGAP: begin
        state_d = (bit_cnt_q == CW'(NBITS)) ? ST_FIN : ST_READ;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered.
    bus_req_d = (state_d == ST_UNLOCK) || (state_d == ST_READ);
    sser_n_d  = !bus_req_d;
    busy_d    = bus_req_d || (state_d == ST_UGAP) || (state_d == ST_RGAP);
    done_d    = (state_d == ST_FIN);
    case (state_d)
      ST_UNLOCK: bus_addr_d = unlock_addr(UNLOCK_SEQ[{idx_d, 2'b00} +: 4]);
      ST_READ:   bus_addr_d = SDRD_WINDOW;
      default:   bus_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      sser_n_q   <= 1'b1;
      bus_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_req_q  <= bus_req_d;
      sser_n_q   <= sser_n_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign data         = data_q;
  assign state_dbg    = state_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.sser_n   = sser_n_q;
  assign bus.br_w     = bus_req_q;
  assign bus.bus_addr = bus_addr_q;

endmodule

// File: tb/tb_sdrd_serial_reader.sv
// Bench for sdrd_serial_reader: a responder model answers bus reads, expected
// request addresses and results are queued per transaction and checked by a monitor.
module tb_sdrd_serial_reader;
  import sdrd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] data;
  sdrd_state_e state_dbg;

  sdrd_serial_reader_if bus_if ();

  sdrd_serial_reader #(
    .NBITS      (16),
    .UNLOCK_LEN (4),
    .UNLOCK_SEQ (32'h0000_98A2),
    .TIMEOUT    (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .data      (data),
    .state_dbg (state_dbg),
    .bus       (bus_if.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish before 300us");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [13:0] addr_exp_q[$];
  logic [32:0] res_exp_q[$];   // {latency[15:0], err, data[15:0]}
  int          n_tests = 0;
  int          n_fail  = 0;
  int          start_cyc = 0;
  logic [13:0] unl_tab [0:3] = '{14'h1020, 14'h10A0, 14'h1080, 14'h1090};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- responder model ----------------
  int          resp_wait = 0;
  int          hang_at   = -1;
  int          rd_acks   = 0;
  int          wait_cnt  = 0;
  logic [15:0] rd_bits   = 16'h0;
  bit          spur_en   = 1'b0;

  always @(negedge clk) begin
    bus_if.bus_ack = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
      bus_if.sdrd_in = 1'b0;
    end else if (bus_if.bus_req) begin
      if (wait_cnt == resp_wait && !(bus_if.bus_addr == 14'h1000 && rd_acks == hang_at)) begin
        bus_if.bus_ack = 1'b1;
        if (bus_if.bus_addr == 14'h1000) begin
          bus_if.sdrd_in = rd_bits[15 - rd_acks];
          rd_acks++;
        end else begin
          bus_if.sdrd_in = 1'($urandom_range(0, 1));
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spur_en) begin
        bus_if.bus_ack = 1'b1;
        bus_if.sdrd_in = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        req_prev = 1'b0;
  logic [13:0] cur_addr = '0;
  logic [13:0] mon_a;
  logic [32:0] mon_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (bus_if.bus_req && !req_prev) begin
        chk("req_sser_n", 32'(bus_if.sser_n), 32'd0);
        chk("req_br_w", 32'(bus_if.br_w), 32'd1);
        if (addr_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%0h expected no request", bus_if.bus_addr);
        end else begin
          mon_a = addr_exp_q.pop_front();
          chk("req_addr", 32'(bus_if.bus_addr), 32'(mon_a));
        end
        cur_addr = bus_if.bus_addr;
      end else if (bus_if.bus_req) begin
        chk("addr_stable", 32'(bus_if.bus_addr), 32'(cur_addr));
      end
      if (done) begin
        chk("done_busy_low", 32'(busy), 32'd0);
        if (res_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          mon_r = res_exp_q.pop_front();
          chk("result_data", 32'(data), 32'(mon_r[15:0]));
          chk("result_err", 32'(err), 32'(mon_r[16]));
          chk("done_cycle", 32'(cyc - start_cyc), 32'(mon_r[32:17]));
        end
      end
      req_prev = bus_if.bus_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_resp(input int w, input int hang, input logic [15:0] bits);
    resp_wait = w;
    hang_at   = hang;
    rd_bits   = bits;
    rd_acks   = 0;
  endtask

  task automatic expect_txn(input int n_unl, input int n_rd, input logic [15:0] d,
                            input logic e, input int lat);
    for (int i = 0; i < n_unl; i++) addr_exp_q.push_back(unl_tab[i]);
    for (int i = 0; i < n_rd; i++) addr_exp_q.push_back(14'h1000);
    res_exp_q.push_back({16'(lat), e, d});
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_txn(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_exp_q.size() == 0) break;
    end
    #1;
    chk("txn_completed", 32'(res_exp_q.size()), 32'd0);
    chk("all_reqs_seen", 32'(addr_exp_q.size()), 32'd0);
    res_exp_q.delete();
    addr_exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_if.bus_req), 32'd0);
    chk({tag, "_sser_n"}, 32'(bus_if.sser_n), 32'd1);
    chk({tag, "_br_w"}, 32'(bus_if.br_w), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_if.bus_addr), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait default transaction
    setup_resp(0, -1, 16'hA5C3);
    expect_txn(4, 16, 16'hA5C3, 1'b0, 41);
    go();
    @(negedge clk);
    chk("cycle1_bus_req", 32'(bus_if.bus_req), 32'd1);
    chk("cycle1_busy", 32'(busy), 32'd1);
    wait_txn(200);

    // three wait cycles per access
    setup_resp(3, -1, 16'hA5C3);
    expect_txn(4, 16, 16'hA5C3, 1'b0, 101);
    go();
    wait_txn(400);

    // ack exactly when the wait counter reaches TIMEOUT still counts
    setup_resp(15, -1, 16'h3C5A);
    expect_txn(4, 16, 16'h3C5A, 1'b0, 341);
    go();
    wait_txn(800);

    // one wait too many: first unlock read times out
    setup_resp(16, -1, 16'hFFFF);
    expect_txn(1, 0, 16'h0000, 1'b1, 17);
    go();
    wait_txn(100);

    // no ack on the 5th bit read: partial data, err held afterwards
    setup_resp(0, 4, 16'hA5C3);
    expect_txn(4, 5, 16'h000A, 1'b1, 33);
    go();
    wait_txn(200);
    repeat (3) @(negedge clk);
    chk("err_held", 32'(err), 32'd1);
    chk("partial_data_held", 32'(data), 32'h000A);

    // start pulses mid-transaction and in the FIN cycle are ignored
    setup_resp(0, -1, 16'h1234);
    expect_txn(4, 16, 16'h1234, 1'b0, 41);
    go();
    repeat (10) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("fin_reached", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("fin_start_busy", 32'(busy), 32'd0);
    chk("fin_start_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("fin_start_data", 32'(data), 32'h1234);
    chk("fin_start_bus_req", 32'(bus_if.bus_req), 32'd0);
    wait_txn(10);

    // spurious acks in IDLE and in the gap cycles
    spur_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("spur_idle_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_data", 32'(data), 32'h1234);
    setup_resp(0, -1, 16'h0F0F);
    expect_txn(4, 16, 16'h0F0F, 1'b0, 41);
    go();
    wait_txn(200);
    spur_en = 1'b0;

    // asynchronous reset during bit 7, then a clean full run
    setup_resp(2, -1, 16'hFFFF);
    expect_txn(4, 16, 16'hFFFF, 1'b0, 81);
    go();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_acks == 6 && bus_if.bus_req) break;
    end
    chk("reached_bit7", 32'(rd_acks), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    addr_exp_q.delete();
    res_exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    setup_resp(0, -1, 16'hA5C3);
    expect_txn(4, 16, 16'hA5C3, 1'b0, 41);
    go();
    wait_txn(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
